// File: rtl/match_pkg.sv
// Shared match-flow types and goal geometry.
// Also used by the colour mapper for the goal rectangles.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    WIN
  } match_state_t;

  localparam int COORD_W       = 10;
  localparam int SCORE_W       = 3;

  localparam int WIN_SCORE     = 3;
  localparam int PAUSE_FRAMES  = 60;

  localparam int GOAL_Y_TOP    = 275;
  localparam int LGOAL_X_END   = 70;
  localparam int RGOAL_X_START = 570;
  localparam int BALL_SIZE     = 33;

  // Saturating score bump; never goes past lim.
  function automatic logic [SCORE_W-1:0] score_inc(
    input logic [SCORE_W-1:0] s,
    input logic [SCORE_W-1:0] lim
  );
    if (s >= lim) begin
      return s;
    end
    return s + 1'b1;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Single-bit rising-edge detector.
// Output is combinational from d and the registered previous value.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  // Remember last sample of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/match_state_ctrl.sv
// Match flow controller: title, play, goal pause, win.
// Owns scores and tells ball/player logic to freeze or recentre.
module match_state_ctrl #(
  parameter int WIN_SCORE     = match_pkg::WIN_SCORE,
  parameter int PAUSE_FRAMES  = match_pkg::PAUSE_FRAMES,
  parameter int GOAL_Y_TOP    = match_pkg::GOAL_Y_TOP,
  parameter int LGOAL_X_END   = match_pkg::LGOAL_X_END,
  parameter int RGOAL_X_START = match_pkg::RGOAL_X_START,
  parameter int BALL_SIZE     = match_pkg::BALL_SIZE
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       game_start,
  output logic       patrick_win,
  output logic       zuofu_win,
  output logic [2:0] patrick_score,
  output logic [2:0] zuofu_score,
  output logic       freeze,
  output logic       ball_reset
);

  import match_pkg::*;

  localparam int CNT_W =
    (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(PAUSE_FRAMES - 1);

  localparam logic [SCORE_W-1:0] WIN_S =
    SCORE_W'(WIN_SCORE);

  localparam logic [10:0] Y_TOP = 11'(GOAL_Y_TOP);
  localparam logic [10:0] LX    = 11'(LGOAL_X_END);
  localparam logic [10:0] RX    = 11'(RGOAL_X_START);
  localparam logic [10:0] BS    = 11'(BALL_SIZE);

  match_state_t       state_q, state_d;
  logic [SCORE_W-1:0] p_q, p_d;
  logic [SCORE_W-1:0] z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pw_q, pw_d;
  logic               zw_q, zw_d;
  logic               br_q, br_d;
  logic               gs_q, fr_q;

  logic               start_press;
  logic               in_mouth;
  logic               goal_l, goal_r;
  logic [10:0]        bx, by, bx_far;

  edge_detect_rise u_start (
    .clk   (CLK),
    .rst_n (Reset),
    .d     (start_key),
    .rise  (start_press)
  );

  // 11-bit geometry so ball_x + BALL_SIZE cannot wrap.
  always_comb begin
    bx       = {1'b0, ball_x};
    by       = {1'b0, ball_y};
    bx_far   = bx + BS;
    in_mouth = (by >= Y_TOP);
    goal_l   = in_mouth && (bx < LX);
    goal_r   = in_mouth && (bx_far > RX);
  end

  // Next-state, score and pulse decisions.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    pw_d    = pw_q;
    zw_d    = zw_q;
    br_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d = PLAY;
          br_d    = 1'b1;
        end
      end

      PLAY: begin
        if (frame_tick) begin
          if (goal_r) begin
            p_d = score_inc(p_q, WIN_S);
            if (p_d == WIN_S) begin
              state_d = WIN;
              pw_d    = 1'b1;
            end else begin
              state_d = PAUSE;
              cnt_d   = '0;
            end
          end else if (goal_l) begin
            z_d = score_inc(z_q, WIN_S);
            if (z_d == WIN_S) begin
              state_d = WIN;
              zw_d    = 1'b1;
            end else begin
              state_d = PAUSE;
              cnt_d   = '0;
            end
          end
        end
      end

      PAUSE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = PLAY;
            br_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WIN: begin
        if (start_press) begin
          state_d = IDLE;
          p_d     = '0;
          z_d     = '0;
          pw_d    = 1'b0;
          zw_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scores and registered outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      pw_q    <= 1'b0;
      zw_q    <= 1'b0;
      br_q    <= 1'b0;
      gs_q    <= 1'b0;
      fr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      pw_q    <= pw_d;
      zw_q    <= zw_d;
      br_q    <= br_d;
      gs_q    <= (state_d != IDLE);
      fr_q    <= (state_d != PLAY);
    end
  end

  assign game_start    = gs_q;
  assign freeze        = fr_q;
  assign ball_reset    = br_q;
  assign patrick_win   = pw_q;
  assign zuofu_win     = zw_q;
  assign patrick_score = p_q;
  assign zuofu_score   = z_q;

endmodule

// File: tb/tb_match_state_ctrl.sv
// Directed bench for match_state_ctrl.
// Second instance widens the left goal so both goals can overlap.
module tb_match_state_ctrl;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_key = 1'b0;
  logic [9:0] ball_x = 10'd320;
  logic [9:0] ball_y = 10'd100;

  logic       gs, pw, zw, fr, br;
  logic [2:0] ps, zs;
  logic       gs2, pw2, zw2, fr2, br2;
  logic [2:0] ps2, zs2;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  match_state_ctrl dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .start_key     (start_key),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .game_start    (gs),
    .patrick_win   (pw),
    .zuofu_win     (zw),
    .patrick_score (ps),
    .zuofu_score   (zs),
    .freeze        (fr),
    .ball_reset    (br)
  );

  match_state_ctrl #(.LGOAL_X_END(600)) dut2 (
    .CLK           (CLK),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .start_key     (start_key),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .game_start    (gs2),
    .patrick_win   (pw2),
    .zuofu_win     (zw2),
    .patrick_score (ps2),
    .zuofu_score   (zs2),
    .freeze        (fr2),
    .ball_reset    (br2)
  );

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         p;
    int         z;
    int         f;
    int         p2;
    int         z2;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset      = 1'b0;
    start_key  = 1'b0;
    frame_tick = 1'b0;
    ball_x     = 10'd320;
    ball_y     = 10'd100;
    step();
    step();
    Reset = 1'b1;
    step();
  endtask

  task automatic press();
    start_key = 1'b1;
    step();
    start_key = 1'b0;
    step();
  endtask

  task automatic tick_at(input int x, input int y);
    ball_x     = 10'(x);
    ball_y     = 10'(y);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic run_pause();
    for (int i = 0; i < 60; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
    ball_x     = 10'd320;
    ball_y     = 10'd100;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;

    vt[0] = '{10'd537, 10'd275, 0, 0, 0, 0, 1};
    vt[1] = '{10'd538, 10'd275, 1, 0, 1, 1, 0};
    vt[2] = '{10'd538, 10'd274, 0, 0, 0, 0, 0};
    vt[3] = '{10'd69,  10'd275, 0, 1, 1, 0, 1};
    vt[4] = '{10'd70,  10'd300, 0, 0, 0, 0, 1};
    vt[5] = '{10'd560, 10'd300, 1, 0, 1, 1, 0};
    vt[6] = '{10'd300, 10'd500, 0, 0, 0, 0, 1};

    // Reset state and single press from a held key.
    do_reset();
    chk("rst_gs", int'(gs), 0);
    chk("rst_fr", int'(fr), 1);
    chk("rst_br", int'(br), 0);
    chk("rst_ps", int'(ps), 0);
    chk("rst_zs", int'(zs), 0);
    chk("rst_win", int'({pw, zw}), 0);

    pulses = 0;
    start_key = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(br);
    end
    start_key = 1'b0;
    chk("hold_pulses", pulses, 1);
    chk("hold_gs", int'(gs), 1);
    chk("hold_fr", int'(fr), 0);

    // Patrick goal, then a full pause with ball left in goal.
    tick_at(560, 300);
    chk("pg_ps", int'(ps), 1);
    chk("pg_zs", int'(zs), 0);
    chk("pg_fr", int'(fr), 1);
    chk("pg_gs", int'(gs), 1);

    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      frame_tick = 1'b1;
      start_key  = (i >= 30 && i < 33);
      step();
      if (i < 60) pulses += int'(br);
      if (i == 59) begin
        chk("p59_pulses", pulses, 0);
        chk("p59_fr", int'(fr), 1);
      end
      if (i == 60) begin
        chk("p60_br", int'(br), 1);
        chk("p60_fr", int'(fr), 0);
        chk("p60_ps", int'(ps), 1);
      end
    end
    frame_tick = 1'b0;
    start_key  = 1'b0;
    ball_x     = 10'd320;
    ball_y     = 10'd100;
    step();
    chk("p61_br", int'(br), 0);
    chk("p61_gs", int'(gs), 1);

    // Zuofu to three and the win.
    tick_at(10, 400);
    run_pause();
    tick_at(10, 400);
    run_pause();
    chk("z2_zs", int'(zs), 2);
    tick_at(10, 400);
    chk("zw_zs", int'(zs), 3);
    chk("zw_zw", int'(zw), 1);
    chk("zw_pw", int'(pw), 0);
    chk("zw_gs", int'(gs), 1);
    chk("zw_ps", int'(ps), 1);
    for (int i = 0; i < 5; i++) begin
      tick_at(10, 400);
    end
    chk("zw_hold_zs", int'(zs), 3);
    chk("zw_hold_zw", int'(zw), 1);

    start_key = 1'b1;
    step();
    start_key = 1'b0;
    chk("wr_ps", int'(ps), 0);
    chk("wr_zs", int'(zs), 0);
    chk("wr_win", int'({pw, zw}), 0);
    chk("wr_gs", int'(gs), 0);
    chk("wr_fr", int'(fr), 1);
    step();

    // Async reset in the middle of a pause.
    do_reset();
    press();
    tick_at(560, 300);
    run_pause();
    tick_at(560, 300);
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
    chk("mp_ps", int'(ps), 2);
    chk("mp_fr", int'(fr), 1);
    Reset = 1'b0;
    #2;
    chk("ar_ps", int'(ps), 0);
    chk("ar_zs", int'(zs), 0);
    chk("ar_fr", int'(fr), 1);
    chk("ar_gs", int'(gs), 0);
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      start_key  = i[0];
      step();
    end
    chk("arh_gs", int'(gs), 0);
    chk("arh_br", int'(br), 0);
    chk("arh_ps", int'(ps), 0);
    frame_tick = 1'b0;
    start_key  = 1'b0;
    Reset      = 1'b1;
    step();
    step();
    chk("rel_gs", int'(gs), 0);
    chk("rel_fr", int'(fr), 1);

    // Boundary and priority vectors.
    for (int k = 0; k < 7; k++) begin
      do_reset();
      press();
      tick_at(int'(vt[k].x), int'(vt[k].y));
      chk($sformatf("v%0d_ps", k), int'(ps), vt[k].p);
      chk($sformatf("v%0d_zs", k), int'(zs), vt[k].z);
      chk($sformatf("v%0d_fr", k), int'(fr), vt[k].f);
      chk($sformatf("v%0d_ps2", k), int'(ps2), vt[k].p2);
      chk($sformatf("v%0d_zs2", k), int'(zs2), vt[k].z2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/match_state_ctrl.md
Name: match_state_ctrl

Overview:
- Upstream of the colour mapper: owns match flow (title, play, goal pause, win) and produces game_start, patrick_win, zuofu_win, patrick_score and zuofu_score.
- Also tells the ball and player movement logic when to freeze and when to recentre.
- Goal detection uses the ball's top-left coordinate against the goal rectangles, evaluated once per frame.

Parameters:
- WIN_SCORE, 3: goals needed to win; scores saturate here.
- PAUSE_FRAMES, 60: frames held in goal pause before the ball recentres.
- GOAL_Y_TOP, 275: top row of both goal mouths.
- LGOAL_X_END, 70: ball_x below this (and in mouth) is a left-goal entry.
- RGOAL_X_START, 570: ball_x + BALL_SIZE above this (and in mouth) is a right-goal entry.
- BALL_SIZE, 33: ball sprite edge length.

Ports:
- CLK  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-CLK pulse per frame (vsync-derived)
- start_key  in  1  keyboard start/restart, level, synchronous to CLK
- ball_x  in  10  ball top-left X
- ball_y  in  10  ball top-left Y
- game_start  out  1  high in PLAY, PAUSE, WIN
- patrick_win  out  1  high in WIN when Patrick won
- zuofu_win  out  1  high in WIN when Zuofu won
- patrick_score  out  3  0..WIN_SCORE
- zuofu_score  out  3  0..WIN_SCORE
- freeze  out  1  high in every state except PLAY
- ball_reset  out  1  one-CLK pulse: recentre ball and players

Behaviour:
- All outputs are registered.
- Reset asserted (Reset=0), effective immediately, any state, including mid-pause: state=IDLE, both scores 0, pause counter 0, win flags 0, game_start=0, freeze=1, ball_reset=0, start edge detector cleared.
- Start press = rising edge of start_key (registered previous value). A held key produces exactly one press.
- goal_L = ball_y >= GOAL_Y_TOP && ball_x < LGOAL_X_END. Goal_L credits Zuofu.
- goal_R = ball_y >= GOAL_Y_TOP && ball_x + BALL_SIZE > RGOAL_X_START. Goal_R credits Patrick.
- Compare using 11-bit sums so the check does not wrap.
- IDLE:
  - Start press -> PLAY, with ball_reset pulsed in the same transition cycle.
- PLAY:
  - Goals are evaluated only on cycles with frame_tick=1.
  - goal_R has priority if goal_R and goal_L are both true.
  - On a goal: the scorer's score increments the next cycle.
  - If the new score == WIN_SCORE -> WIN, with the matching win flag set that cycle.
  - Otherwise -> PAUSE, with the counter loaded to 0.
  - No goal: stay in PLAY.
- PAUSE:
  - Counter increments on each frame_tick.
  - When the counter reaches PAUSE_FRAMES-1 and a frame_tick arrives: -> PLAY, with ball_reset pulsed.
  - Goals are ignored here, even though the ball still sits in the goal.
- WIN:
  - Scores and win flag held.
  - Start press: scores cleared, win flags cleared, -> IDLE (title banner reappears).
  - A start press arriving in the same cycle as the WIN entry is not possible, because WIN is only entered from PLAY.
- Start presses in PLAY and PAUSE are ignored.
- Scores never exceed WIN_SCORE. An increment at WIN_SCORE is blocked by construction.
- frame_tick and a start press in the same cycle: the state's own rule applies; only one transition per cycle.
- Latency:
  - Goal visible on frame_tick -> score output updated 1 CLK later.
  - PAUSE exit -> ball_reset high for exactly 1 CLK.

Decomposition:
- Package match_pkg:
  - enum match_state_t {IDLE, PLAY, PAUSE, WIN}
  - Goal geometry and size constants (shared with the colour mapper's goal rectangles)
  - WIN_SCORE
- Sub-module edge_detect_rise (single-bit rising-edge detector, async active-low reset), reused for start_key. A second instance can be added later for vsync-to-frame_tick.

Test Plan:
- Reset low mid-PAUSE with patrick_score=2 -> immediately state IDLE, scores 0/0, freeze=1, game_start=0; outputs held until Reset released.
- IDLE, start_key held high for 10 cycles -> exactly one ball_reset pulse, game_start=1, freeze=0; no second transition.
- PLAY, ball_x=560, ball_y=300, frame_tick -> next CLK patrick_score=1, state PAUSE, freeze=1.
- Then 60 frame_ticks with the ball left in the goal -> score stays 1; ball_reset pulses once on tick 60; back to PLAY.
- Zuofu at 2, ball_x=10, ball_y=400, frame_tick -> zuofu_score=3, zuofu_win=1, patrick_win=0, game_start=1.
- Further frame_ticks in the goal -> score stays 3.
- Start press in WIN -> scores 0, flags 0, IDLE.
- Boundaries and priority:
  - ball_x=537, ball_y=275 (sum 570, not >570) -> no goal.
  - ball_x=538 -> Patrick goal.
  - ball_y=274 -> no goal.
  - Forced goal_L and goal_R together -> Patrick credited only.
